// File: rtl/dcache_store_buffer.sv
// Retired-store FIFO feeding dcache_control: up to two enqueues per cycle, one
// head store presented to memory, and youngest-match store-to-load forwarding.
module dcache_store_buffer #(
  parameter int unsigned SB_DEPTH = 8
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [1:0]                     retire_st_valid,
  input  logic [127:0]                   retire_st_addr,
  input  logic [127:0]                   retire_st_data,
  input  logic [3:0]                     Dmem2proc_response,
  input  logic [63:0]                    ld_addr_0,
  input  logic [63:0]                    ld_addr_1,
  output logic                           store_valid,
  output logic [63:0]                    proc2Dcache_addr_st,
  output logic [63:0]                    proc2Dmem_data,
  output logic [$clog2(SB_DEPTH+1)-1:0]  sb_free_count,
  output logic                           sb_empty,
  output logic                           fwd_hit_0,
  output logic                           fwd_hit_1,
  output logic [63:0]                    fwd_data_0,
  output logic [63:0]                    fwd_data_1,
  output logic                           sb_overflow_err
);

  localparam int unsigned PW = $clog2(SB_DEPTH);
  localparam int unsigned CW = $clog2(SB_DEPTH + 1);

  logic [SB_DEPTH-1:0] valid_q, valid_d;
  logic [63:0]         addr_q [SB_DEPTH];
  logic [63:0]         addr_d [SB_DEPTH];
  logic [63:0]         data_q [SB_DEPTH];
  logic [63:0]         data_d [SB_DEPTH];
  logic [PW-1:0]       head_q, head_d;
  logic [PW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;
  logic                ovf_q, ovf_d;

  logic [CW-1:0] free_slots;
  logic          pop;
  logic          acc0, acc1;
  logic [1:0]    n_acc;
  logic [PW-1:0] slot1;
  logic          drop;

  // Capacity uses registered count only, so a slot freed by this cycle's pop
  // cannot be refilled until the next cycle.
  always_comb begin
    free_slots = CW'(SB_DEPTH) - count_q;
    pop        = valid_q[head_q] && (Dmem2proc_response != '0);
    acc0       = retire_st_valid[0] && (free_slots >= CW'(1));
    acc1       = retire_st_valid[1] && (acc0 ? (free_slots >= CW'(2)) : (free_slots >= CW'(1)));
    n_acc      = {1'b0, acc0} + {1'b0, acc1};
    slot1      = acc0 ? (tail_q + PW'(1)) : tail_q;
    drop       = (retire_st_valid[0] && !acc0) || (retire_st_valid[1] && !acc1);
  end

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      addr_d[head_q]  = '0;
      data_d[head_q]  = '0;
    end
    if (acc0) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = retire_st_addr[63:0];
      data_d[tail_q]  = retire_st_data[63:0];
    end
    if (acc1) begin
      valid_d[slot1] = 1'b1;
      addr_d[slot1]  = retire_st_addr[127:64];
      data_d[slot1]  = retire_st_data[127:64];
    end
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(n_acc);
    count_d = count_q + CW'(n_acc) - CW'(pop);
    ovf_d   = ovf_q | drop;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      addr_q  <= '{default: '0};
      data_q  <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    store_valid         = valid_q[head_q];
    proc2Dcache_addr_st = store_valid ? addr_q[head_q] : '0;
    proc2Dmem_data      = store_valid ? data_q[head_q] : '0;
    sb_free_count       = free_slots;
    sb_empty            = (count_q == '0);
    sb_overflow_err     = ovf_q;
  end

  // Scan oldest to youngest from head so the last match wins (youngest store).
  always_comb begin
    logic [PW-1:0] idx;
    idx        = '0;
    fwd_hit_0  = 1'b0;
    fwd_hit_1  = 1'b0;
    fwd_data_0 = '0;
    fwd_data_1 = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (valid_q[idx] && (addr_q[idx][63:3] == ld_addr_0[63:3])) begin
        fwd_hit_0  = 1'b1;
        fwd_data_0 = data_q[idx];
      end
      if (valid_q[idx] && (addr_q[idx][63:3] == ld_addr_1[63:3])) begin
        fwd_hit_1  = 1'b1;
        fwd_data_1 = data_q[idx];
      end
    end
  end

endmodule

// File: tb/tb_dcache_store_buffer.sv
// Directed bench for dcache_store_buffer: a queue model of buffered stores is
// advanced with every driven cycle and compared against all outputs.
module tb_dcache_store_buffer;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   retire_st_valid;
  logic [127:0] retire_st_addr;
  logic [127:0] retire_st_data;
  logic [3:0]   Dmem2proc_response;
  logic [63:0]  ld_addr_0;
  logic [63:0]  ld_addr_1;
  logic         store_valid;
  logic [63:0]  proc2Dcache_addr_st;
  logic [63:0]  proc2Dmem_data;
  logic [3:0]   sb_free_count;
  logic         sb_empty;
  logic         fwd_hit_0, fwd_hit_1;
  logic [63:0]  fwd_data_0, fwd_data_1;
  logic         sb_overflow_err;

  dcache_store_buffer #(.SB_DEPTH(8)) dut (
    .clock               (clock),
    .reset               (reset),
    .retire_st_valid     (retire_st_valid),
    .retire_st_addr      (retire_st_addr),
    .retire_st_data      (retire_st_data),
    .Dmem2proc_response  (Dmem2proc_response),
    .ld_addr_0           (ld_addr_0),
    .ld_addr_1           (ld_addr_1),
    .store_valid         (store_valid),
    .proc2Dcache_addr_st (proc2Dcache_addr_st),
    .proc2Dmem_data      (proc2Dmem_data),
    .sb_free_count       (sb_free_count),
    .sb_empty            (sb_empty),
    .fwd_hit_0           (fwd_hit_0),
    .fwd_hit_1           (fwd_hit_1),
    .fwd_data_0          (fwd_data_0),
    .fwd_data_1          (fwd_data_1),
    .sb_overflow_err     (sb_overflow_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] a;
    logic [63:0] d;
  } st_t;

  st_t sb_q[$];
  logic m_ovf;
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_fwd(input logic [63:0] la, output logic hit, output logic [63:0] d);
    hit = 1'b0;
    d   = '0;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (!hit && sb_q[i].a[63:3] == la[63:3]) begin
        hit = 1'b1;
        d   = sb_q[i].d;
      end
    end
  endtask

  // One clock: drive inputs, check outputs against the model, advance model.
  task automatic cycle(input logic [1:0] v, input logic [63:0] a0, input logic [63:0] d0,
                       input logic [63:0] a1, input logic [63:0] d1, input logic [3:0] resp);
    logic        h;
    logic [63:0] fd;
    int          slots;
    retire_st_valid    = v;
    retire_st_addr     = {a1, a0};
    retire_st_data     = {d1, d0};
    Dmem2proc_response = resp;
    #1;
    chk("store_valid", 64'(store_valid), 64'(sb_q.size() != 0));
    chk("head_addr", proc2Dcache_addr_st, (sb_q.size() != 0) ? sb_q[0].a : 64'h0);
    chk("head_data", proc2Dmem_data, (sb_q.size() != 0) ? sb_q[0].d : 64'h0);
    chk("free_count", 64'(sb_free_count), 64'(8 - sb_q.size()));
    chk("empty", 64'(sb_empty), 64'(sb_q.size() == 0));
    chk("overflow_err", 64'(sb_overflow_err), 64'(m_ovf));
    model_fwd(ld_addr_0, h, fd);
    chk("fwd_hit_0", 64'(fwd_hit_0), 64'(h));
    chk("fwd_data_0", fwd_data_0, fd);
    model_fwd(ld_addr_1, h, fd);
    chk("fwd_hit_1", 64'(fwd_hit_1), 64'(h));
    chk("fwd_data_1", fwd_data_1, fd);
    slots = 8 - sb_q.size();
    if (sb_q.size() != 0 && resp != 4'd0) void'(sb_q.pop_front());
    if (v[0]) begin
      if (slots > 0) begin sb_q.push_back('{a: a0, d: d0}); slots--; end
      else m_ovf = 1'b1;
    end
    if (v[1]) begin
      if (slots > 0) begin sb_q.push_back('{a: a1, d: d1}); slots--; end
      else m_ovf = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic [3:0] resp, input int n);
    for (int i = 0; i < n; i++) cycle(2'b00, '0, '0, '0, '0, resp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    sb_q.delete();
    m_ovf = 1'b0;
  endtask

  initial begin
    int sent;
    reset = 1'b1;
    retire_st_valid = '0;
    retire_st_addr = '0;
    retire_st_data = '0;
    Dmem2proc_response = '0;
    ld_addr_0 = '0;
    ld_addr_1 = '0;
    m_ovf = 1'b0;
    do_reset();

    // Reset and idle
    chk("rst_store_valid", 64'(store_valid), 64'h0);
    chk("rst_free", 64'(sb_free_count), 64'd8);
    chk("rst_empty", 64'(sb_empty), 64'h1);
    chk("rst_hit0", 64'(fwd_hit_0), 64'h0);
    idle(4'd0, 2);

    // Two stores, always accepted
    cycle(2'b11, 64'h100, 64'h11, 64'h108, 64'h22, 4'd3);
    chk("lat_A_addr", proc2Dcache_addr_st, 64'h100);
    chk("lat_A_data", proc2Dmem_data, 64'h11);
    cycle(2'b00, '0, '0, '0, '0, 4'd3);
    chk("then_B_addr", proc2Dcache_addr_st, 64'h108);
    cycle(2'b00, '0, '0, '0, '0, 4'd3);
    chk("drained_valid", 64'(store_valid), 64'h0);
    chk("drained_free", 64'(sb_free_count), 64'd8);
    idle(4'd3, 1);

    // Retry: held for 4 rejected cycles, popped on the 5th
    cycle(2'b01, 64'h200, 64'h33, '0, '0, 4'd0);
    idle(4'd0, 4);
    chk("retry_held_addr", proc2Dcache_addr_st, 64'h200);
    idle(4'd5, 1);
    chk("retry_popped", 64'(store_valid), 64'h0);
    idle(4'd0, 1);

    // Fill, overflow, full with pop
    for (int i = 0; i < 4; i++)
      cycle(2'b11, 64'h400 + 64'(16 * i), 64'hA0 + 64'(i), 64'h408 + 64'(16 * i), 64'hB0 + 64'(i), 4'd0);
    cycle(2'b11, 64'h480, 64'hEE, 64'h488, 64'hFF, 4'd0);
    chk("ovf_set", 64'(sb_overflow_err), 64'h1);
    chk("ovf_free0", 64'(sb_free_count), 64'd0);
    cycle(2'b11, 64'h490, 64'hEE, 64'h498, 64'hFF, 4'd1);
    chk("full_pop_free", 64'(sb_free_count), 64'd1);
    idle(4'd1, 8);
    chk("ovf_sticky", 64'(sb_overflow_err), 64'h1);
    do_reset();
    idle(4'd0, 1);

    // Forwarding: youngest of two matching stores
    cycle(2'b11, 64'h300, 64'hAA, 64'h300, 64'hBB, 4'd0);
    ld_addr_0 = 64'h304;
    ld_addr_1 = 64'h308;
    cycle(2'b00, '0, '0, '0, '0, 4'd0);
    chk("fwd0_hit", 64'(fwd_hit_0), 64'h1);
    chk("fwd0_data", fwd_data_0, 64'hBB);
    chk("fwd1_miss", 64'(fwd_hit_1), 64'h0);
    chk("fwd1_data", fwd_data_1, 64'h0);
    // Head being popped this cycle still forwards
    ld_addr_1 = 64'h300;
    cycle(2'b00, '0, '0, '0, '0, 4'd2);
    idle(4'd2, 2);

    // Mid-operation reset discards everything
    cycle(2'b11, 64'h500, 64'h1, 64'h508, 64'h2, 4'd0);
    Dmem2proc_response = 4'd2;
    do_reset();
    chk("midrst_valid", 64'(store_valid), 64'h0);
    chk("midrst_free", 64'(sb_free_count), 64'd8);
    idle(4'd2, 1);

    // Wrap: 20 stores, response alternating 0/2, retire gated on free slots
    sent = 0;
    for (int k = 0; k < 60 && sent < 20; k++) begin
      ld_addr_0 = 64'h1000 + 64'(8 * (sent > 2 ? sent - 2 : 0));
      ld_addr_1 = 64'h1000 + 64'(8 * sent);
      if (sb_q.size() < 8) begin
        cycle(2'b01, 64'h1000 + 64'(8 * sent), 64'hD000 + 64'(sent), '0, '0, (k % 2 == 0) ? 4'd0 : 4'd2);
        sent++;
      end else begin
        cycle(2'b00, '0, '0, '0, '0, (k % 2 == 0) ? 4'd0 : 4'd2);
      end
    end
    chk("wrap_all_sent", 64'(sent), 64'd20);
    idle(4'd2, 10);
    chk("wrap_empty", 64'(sb_empty), 64'h1);
    chk("wrap_no_ovf", 64'(sb_overflow_err), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
